// File: rtl/fifo_read_checker.sv
// Read-side consumer/checker for the asynchronous FIFO, entirely in the rclk domain.
// After a start pulse it pops num_words words and checks each one against an incrementing
// reference sequence that begins at seed. It reports how many words it compared, how many
// mismatched, the first mismatch, completion, and whether the run ended by starvation timeout.
// Optional build macro FIFO_RD_THROTTLE_EN: an LFSR randomly withholds r_en to emulate a slow
// consumer.
module fifo_read_checker #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned READ_LAT   = 1,
  parameter int unsigned TIMEOUT    = 256
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  num_words,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  r_en,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic [CNT_WIDTH-1:0]  rcv_count,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [DATA_WIDTH-1:0] err_data,
  output logic [DATA_WIDTH-1:0] err_exp
);

  typedef enum logic [1:0] {StIdle, StDrain, StFlush, StDone} state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  num_q;
  logic [CNT_WIDTH-1:0]  issued_q;
  logic [DATA_WIDTH-1:0] exp_q;
  logic [31:0]           starve_q;
  logic [READ_LAT-1:0]   vld_q, vld_d;
  logic [READ_LAT-1:0]   vld_older;

  logic start_ok;
  logic hold;
  logic starve_inc;
  logic timeout_hit;
  logic last_issue;
  logic compare;
  logic in_flight_after;

  assign start_ok = start && ((state_q == StIdle) || (state_q == StDone));

`ifdef FIFO_RD_THROTTLE_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign hold    = (state_q == StDrain) && (lfsr_q[1:0] == 2'b00);

  // Free-running throttle LFSR, re-seeded on every accepted start
  always_ff @(posedge rclk) begin
    if (rrst || start_ok) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
    end
  end
`else
  assign hold = 1'b0;
`endif

  // Pipeline bookkeeping, starvation detection and end-of-issue detection
  always_comb begin
    vld_d           = vld_q << 1;
    vld_d[0]        = r_en;
    compare         = vld_q[READ_LAT-1];
    // Reads still outstanding once this cycle's emerging read has been compared
    vld_older       = vld_q;
    vld_older[READ_LAT-1] = 1'b0;
    in_flight_after = |vld_older;
    starve_inc      = (state_q == StDrain) && empty && !hold;
    timeout_hit     = (TIMEOUT != 0) && starve_inc && ((starve_q + 32'd1) == TIMEOUT);
    last_issue      = r_en && ((issued_q + CNT_WIDTH'(1)) == num_q);
  end

  // FSM state register
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_ok) begin
          state_d = (num_words == '0) ? StDone : StDrain;
        end
      end
      StDrain: begin
        if (last_issue || timeout_hit) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        if (!in_flight_after) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs; r_en is forced low whenever reset is asserted
  always_comb begin
    r_en = (state_q == StDrain) && (issued_q < num_q) && !empty && !hold && !rrst;
    busy = (state_q == StDrain) || (state_q == StFlush);
    done = (state_q == StDone);
  end

  // Run datapath: issue/starve counters, compare pipeline, error capture
  always_ff @(posedge rclk) begin
    if (rrst) begin
      num_q     <= '0;
      issued_q  <= '0;
      exp_q     <= '0;
      starve_q  <= '0;
      vld_q     <= '0;
      timeout   <= 1'b0;
      rcv_count <= '0;
      err_count <= '0;
      err_data  <= '0;
      err_exp   <= '0;
    end else if (start_ok) begin
      num_q     <= num_words;
      issued_q  <= '0;
      exp_q     <= seed;
      starve_q  <= '0;
      vld_q     <= '0;
      timeout   <= 1'b0;
      rcv_count <= '0;
      err_count <= '0;
      err_data  <= '0;
      err_exp   <= '0;
    end else begin
      vld_q <= vld_d;
      if (r_en) begin
        issued_q <= issued_q + CNT_WIDTH'(1);
        starve_q <= '0;
      end else if (starve_inc) begin
        starve_q <= starve_q + 32'd1;
      end
      if (timeout_hit) begin
        timeout <= 1'b1;
      end
      if (compare) begin
        rcv_count <= rcv_count + CNT_WIDTH'(1);
        // Reference advances on every compare; no resync to received data
        exp_q     <= exp_q + DATA_WIDTH'(1);
        if (rd_data != exp_q) begin
          if (err_count != '1) begin
            err_count <= err_count + CNT_WIDTH'(1);
          end
          if (err_count == '0) begin
            err_data <= rd_data;
            err_exp  <= exp_q;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_read_checker.sv
// Bench for fifo_read_checker: a queue-based FIFO model with READ_LAT-deep read latency, a
// per-run scoreboard of popped words, and a negedge compare process that checks outputs.
module tb_fifo_read_checker;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;
  localparam int unsigned RL = 2;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rrst;
  logic          start;
  logic [CW-1:0] num_words;
  logic [DW-1:0] seed;
  logic          empty = 1'b1;
  logic [DW-1:0] rd_data = '0;
  logic          r_en;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [CW-1:0] rcv_count;
  logic [CW-1:0] err_count;
  logic [DW-1:0] err_data;
  logic [DW-1:0] err_exp;

  int n_chk  = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  // FIFO model and scoreboard state
  logic [DW-1:0] q[$];
  logic [DW-1:0] pipe [RL];
  logic          ren_s = 1'b0;
  logic [DW-1:0] pop_v;
  logic [DW-1:0] want_v;
  int            m_num = 0;
  logic [DW-1:0] m_seed = '0;
  int            m_pops = 0;
  int            m_err = 0;
  logic [DW-1:0] m_edata = '0;
  logic [DW-1:0] m_eexp = '0;
  int            ren_total = 0;
  int            busy_total = 0;
  int            ren_base = 0;
  int            busy_base = 0;

  fifo_read_checker #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW),
    .READ_LAT  (RL),
    .TIMEOUT   (TO)
  ) dut (
    .rclk     (clk),
    .rrst     (rrst),
    .start    (start),
    .num_words(num_words),
    .seed     (seed),
    .empty    (empty),
    .rd_data  (rd_data),
    .r_en     (r_en),
    .busy     (busy),
    .done     (done),
    .timeout  (timeout),
    .rcv_count(rcv_count),
    .err_count(err_count),
    .err_data (err_data),
    .err_exp  (err_exp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) ren_s = r_en;

  // FIFO model: pops on a sampled r_en, delivers data RL cycles later, scores each popped word
  always @(posedge clk) begin
    #1;
    for (int i = RL - 1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = '0;
    if (ren_s) begin
      if (q.size() > 0) begin
        pop_v   = q.pop_front();
        pipe[0] = pop_v;
        want_v  = m_seed + DW'(m_pops);
        if (pop_v != want_v) begin
          if (m_err == 0) begin
            m_edata = pop_v;
            m_eexp  = want_v;
          end
          m_err++;
        end
        m_pops++;
      end else begin
        chk("pop_from_empty", 32'd1, 32'd0);
      end
    end
    rd_data = pipe[RL-1];
    empty   = (q.size() == 0);
  end

  // Per-cycle compare against the scoreboard
  always @(negedge clk) begin
    if (chk_en) begin
      if (rrst) begin
        chk("ren_in_reset", {31'd0, r_en}, 32'd0);
      end else begin
        if (r_en) begin
          ren_total++;
          chk("ren_not_empty", {31'd0, empty}, 32'd0);
          chk("ren_within_count", {31'd0, (m_pops < m_num)}, 32'd1);
        end
        if (busy) busy_total++;
        if (done) begin
          chk("done_busy", {31'd0, busy}, 32'd0);
          chk("done_rcv", {16'd0, rcv_count}, 32'(m_pops));
          chk("done_err", {16'd0, err_count}, 32'(m_err));
          chk("done_edata", {24'd0, err_data}, {24'd0, m_edata});
          chk("done_eexp", {24'd0, err_exp}, {24'd0, m_eexp});
          chk("done_timeout", {31'd0, timeout}, {31'd0, (m_pops < m_num)});
        end else if (!busy) begin
          chk("idle_rcv", {16'd0, rcv_count}, 32'd0);
          chk("idle_err", {16'd0, err_count}, 32'd0);
          chk("idle_edata", {24'd0, err_data}, 32'd0);
          chk("idle_eexp", {24'd0, err_exp}, 32'd0);
          chk("idle_timeout", {31'd0, timeout}, 32'd0);
          chk("idle_ren", {31'd0, r_en}, 32'd0);
        end
      end
    end
  end

  task automatic preload(input int n, input logic [DW-1:0] first, input int bad_idx,
                         input logic [DW-1:0] bad_val);
    @(negedge clk);
    q.delete();
    for (int i = 0; i < n; i++) begin
      q.push_back((i == bad_idx) ? bad_val : first + DW'(i));
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic do_start(input logic [CW-1:0] n, input logic [DW-1:0] s);
    @(posedge clk);
    #1;
    start     = 1'b1;
    num_words = n;
    seed      = s;
    @(posedge clk);
    #1;
    start     = 1'b0;
    m_num     = int'(n);
    m_seed    = s;
    m_pops    = 0;
    m_err     = 0;
    m_edata   = '0;
    m_eexp    = '0;
    ren_base  = ren_total;
    busy_base = busy_total;
  endtask

  task automatic wait_done(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk({name, "_done_seen"}, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    rrst = 1'b1;
    start = 1'b0;
    num_words = '0;
    seed = '0;
    for (int i = 0; i < RL; i++) pipe[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    rrst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_ren", {31'd0, r_en}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rcv", {16'd0, rcv_count}, 32'd0);

    // Clean run 0..7
    preload(8, 8'h00, -1, 8'h00);
    do_start(16'd8, 8'h00);
    wait_done("clean");
    chk("clean_ren_cycles", 32'(ren_total - ren_base), 32'd8);
    chk("clean_rcv", {16'd0, rcv_count}, 32'd8);
    chk("clean_err", {16'd0, err_count}, 32'd0);
    chk("clean_timeout", {31'd0, timeout}, 32'd0);

    // Word 3 corrupted
    preload(8, 8'h00, 3, 8'hAA);
    do_start(16'd8, 8'h00);
    wait_done("corrupt");
    chk("corrupt_err", {16'd0, err_count}, 32'd1);
    chk("corrupt_edata", {24'd0, err_data}, 32'h0000_00AA);
    chk("corrupt_eexp", {24'd0, err_exp}, 32'h0000_0003);
    chk("corrupt_rcv", {16'd0, rcv_count}, 32'd8);

    // Reference wraps FE,FF,00,01
    preload(4, 8'hFE, -1, 8'h00);
    do_start(16'd4, 8'hFE);
    wait_done("wrap");
    chk("wrap_err", {16'd0, err_count}, 32'd0);
    chk("wrap_rcv", {16'd0, rcv_count}, 32'd4);

    // Zero-length run completes immediately
    do_start(16'd0, 8'h55);
    chk("zero_done_next", {31'd0, done}, 32'd1);
    repeat (3) @(negedge clk);
    chk("zero_ren_cycles", 32'(ren_total - ren_base), 32'd0);
    chk("zero_rcv", {16'd0, rcv_count}, 32'd0);

    // Starved run times out after TO empty cycles plus one flush cycle
    preload(0, 8'h00, -1, 8'h00);
    do_start(16'd4, 8'h00);
    wait_done("starve");
    chk("starve_timeout", {31'd0, timeout}, 32'd1);
    chk("starve_rcv", {16'd0, rcv_count}, 32'd0);
    chk("starve_busy_cycles", 32'(busy_total - busy_base), 32'd17);

    // Reset three words into an eight-word drain
    preload(8, 8'h00, -1, 8'h00);
    do_start(16'd8, 8'h00);
    begin
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin
        @(posedge clk);
        if (ren_total - ren_base >= 3) hit = 1'b1;
      end
      chk("midrst_three_issued", {31'd0, hit}, 32'd1);
    end
    #1;
    rrst = 1'b1;
    @(posedge clk);
    #1;
    rrst = 1'b0;
    @(negedge clk);
    chk("midrst_ren", {31'd0, r_en}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_rcv", {16'd0, rcv_count}, 32'd0);
    chk("midrst_err", {16'd0, err_count}, 32'd0);
    chk("midrst_timeout", {31'd0, timeout}, 32'd0);
    preload(8, 8'h40, -1, 8'h00);
    do_start(16'd8, 8'h40);
    wait_done("rerun");
    chk("rerun_err", {16'd0, err_count}, 32'd0);
    chk("rerun_rcv", {16'd0, rcv_count}, 32'd8);
    chk("rerun_ren_cycles", 32'(ren_total - ren_base), 32'd8);
    chk("rerun_timeout", {31'd0, timeout}, 32'd0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
